// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared encodings for the multicycle RV32 control path
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALUOp codes, also consumed by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REGA  = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

  // Bundle of every decoded control output, so reset can clear them in one place
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/main_control_fsm_if.sv
// rtl/main_control_fsm_if.sv - control FSM to datapath signal bundle
interface main_control_fsm_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       PCSource;
  logic       illegal_op;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, instr_done, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, instr_done, state
  );
endinterface

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle RV32 main control state machine
module main_control_fsm
  import multicycle_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  main_control_fsm_if.master    bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  ctrl_t  ctrl_o;

  // State register; reset parks the machine in FETCH
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d = S_FETCH;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        if (bus.mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target OldPC+imm into ALUOut
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        case (bus.opcode)
          OP_RTYPE:          state_d = S_EXECUTE;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            ctrl.illegal_op = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        if (bus.opcode == OP_LOAD)       state_d = S_MEM_READ;
        else if (bus.opcode == OP_STORE) state_d = S_MEM_WRITE;
        else                             state_d = S_FETCH;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
        state_d       = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.ior_d      = 1'b1;
        ctrl.instr_done = bus.mem_ready;
        state_d         = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        // PC write is qualified by ALU zero in the datapath
        ctrl.alu_src_a     = SRCA_REGA;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
        state_d            = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset suppresses every strobe immediately, dropping any in-flight access
  assign ctrl_o          = reset ? ctrl : '0;
  assign bus.state       = reset ? state_q : S_FETCH;
  assign bus.PCWrite     = ctrl_o.pc_write;
  assign bus.PCWriteCond = ctrl_o.pc_write_cond;
  assign bus.IorD        = ctrl_o.ior_d;
  assign bus.MemRead     = ctrl_o.mem_read;
  assign bus.MemWrite    = ctrl_o.mem_write;
  assign bus.MemtoReg    = ctrl_o.mem_to_reg;
  assign bus.IRWrite     = ctrl_o.ir_write;
  assign bus.RegWrite    = ctrl_o.reg_write;
  assign bus.ALUSrcA     = ctrl_o.alu_src_a;
  assign bus.ALUSrcB     = ctrl_o.alu_src_b;
  assign bus.ALUOp       = ctrl_o.alu_op;
  assign bus.PCSource    = ctrl_o.pc_source;
  assign bus.illegal_op  = ctrl_o.illegal_op;
  assign bus.instr_done  = ctrl_o.instr_done;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - scoreboard bench for main_control_fsm
module tb_main_control_fsm;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       illegal_op;
    logic       instr_done;
  } out_t;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  out_t sb[$];
  out_t got;
  out_t want;

  main_control_fsm_if bus();

  main_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic out_t e_zero();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t e_fetch(input logic r);
    out_t o = '0;
    o.state = 4'd0; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
    o.ir_write = r; o.pc_write = r;
    return o;
  endfunction

  function automatic out_t e_decode(input logic legal);
    out_t o = '0;
    o.state = 4'd1; o.alu_src_a = 2'b10; o.alu_src_b = 2'b10;
    o.illegal_op = !legal; o.instr_done = !legal;
    return o;
  endfunction

  function automatic out_t e_mem_addr();
    out_t o = '0;
    o.state = 4'd2; o.alu_src_a = 2'b01; o.alu_src_b = 2'b10;
    return o;
  endfunction

  function automatic out_t e_mem_read();
    out_t o = '0;
    o.state = 4'd3; o.mem_read = 1'b1; o.ior_d = 1'b1;
    return o;
  endfunction

  function automatic out_t e_mem_wb();
    out_t o = '0;
    o.state = 4'd4; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic out_t e_mem_write(input logic r);
    out_t o = '0;
    o.state = 4'd5; o.mem_write = 1'b1; o.ior_d = 1'b1; o.instr_done = r;
    return o;
  endfunction

  function automatic out_t e_execute();
    out_t o = '0;
    o.state = 4'd6; o.alu_src_a = 2'b01; o.alu_op = 2'b10;
    return o;
  endfunction

  function automatic out_t e_alu_wb();
    out_t o = '0;
    o.state = 4'd7; o.reg_write = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic out_t e_branch();
    out_t o = '0;
    o.state = 4'd8; o.alu_src_a = 2'b01; o.alu_op = 2'b01;
    o.pc_write_cond = 1'b1; o.pc_source = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.state = bus.state; o.pc_write = bus.PCWrite; o.pc_write_cond = bus.PCWriteCond;
    o.ior_d = bus.IorD; o.mem_read = bus.MemRead; o.mem_write = bus.MemWrite;
    o.mem_to_reg = bus.MemtoReg; o.ir_write = bus.IRWrite; o.reg_write = bus.RegWrite;
    o.alu_src_a = bus.ALUSrcA; o.alu_src_b = bus.ALUSrcB; o.alu_op = bus.ALUOp;
    o.pc_source = bus.PCSource; o.illegal_op = bus.illegal_op; o.instr_done = bus.instr_done;
    return o;
  endfunction

  // Apply one cycle of stimulus away from the rising edge and queue its expectation
  task automatic drive(input logic [6:0] op, input logic rdy, input logic rst, input out_t exp);
    @(negedge clk);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    reset         = rst;
    sb.push_back(exp);
    #2;
  endtask

  task automatic test_reset();
    out_t exp_seq[6];
    exp_seq = '{e_zero(), e_zero(), e_zero(), e_fetch(1'b1), e_decode(1'b0), e_fetch(1'b1)};
    for (int i = 0; i < 5; i++) begin
      drive(OPC_BAD, 1'b1, (i >= 3), exp_seq[i]);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_rtype();
    out_t exp_seq[4];
    exp_seq = '{e_fetch(1'b1), e_decode(1'b1), e_execute(), e_alu_wb()};
    for (int i = 0; i < 4; i++) begin
      drive(OPC_R, 1'b1, 1'b1, exp_seq[i]);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL rtype[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_load_stall();
    out_t exp_seq[7];
    logic [6:0] rdy = 7'b1100111;
    exp_seq = '{e_fetch(1'b1), e_decode(1'b1), e_mem_addr(), e_mem_read(), e_mem_read(),
                e_mem_read(), e_mem_wb()};
    for (int i = 0; i < 7; i++) begin
      drive(OPC_LW, rdy[i], 1'b1, exp_seq[i]);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL load_stall[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_store_stall();
    out_t exp_seq[6];
    logic [5:0] rdy = 6'b100010;
    exp_seq = '{e_fetch(1'b0), e_fetch(1'b1), e_decode(1'b1), e_mem_addr(),
                e_mem_write(1'b0), e_mem_write(1'b1)};
    for (int i = 0; i < 6; i++) begin
      drive(OPC_SW, rdy[i], 1'b1, exp_seq[i]);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL store_stall[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_branch();
    out_t exp_seq[3];
    exp_seq = '{e_fetch(1'b1), e_decode(1'b1), e_branch()};
    for (int i = 0; i < 3; i++) begin
      drive(OPC_BEQ, 1'b1, 1'b1, exp_seq[i]);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL branch[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_illegal();
    out_t exp_seq[3];
    exp_seq = '{e_fetch(1'b1), e_decode(1'b0), e_fetch(1'b0)};
    for (int i = 0; i < 3; i++) begin
      drive(OPC_BAD, (i != 2), 1'b1, exp_seq[i]);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL illegal[%0d] got=%h want=%h", i, got, want);
      end
    end
    // the stalled fetch above is left pending; complete it as an R-type
    for (int i = 0; i < 4; i++) begin
      drive(OPC_R, 1'b1, 1'b1, (i == 0) ? e_fetch(1'b1) : (i == 1) ? e_decode(1'b1)
            : (i == 2) ? e_execute() : e_alu_wb());
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL illegal_follow[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_t exp_seq[8];
    logic [6:0] ops[8];
    logic [7:0] rdy = 8'b1110_0111;
    logic [7:0] rst = 8'b1110_1111;
    exp_seq = '{e_fetch(1'b1), e_decode(1'b1), e_mem_addr(), e_mem_read(), e_zero(),
                e_fetch(1'b1), e_decode(1'b1), e_branch()};
    ops = '{OPC_LW, OPC_LW, OPC_LW, OPC_LW, OPC_LW, OPC_BEQ, OPC_BEQ, OPC_BEQ};
    for (int i = 0; i < 8; i++) begin
      drive(ops[i], rdy[i], rst[i], exp_seq[i]);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset_mid[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  // R-type, sw, beq with no idle gap; mem_ready toggles in non-memory states
  task automatic test_back_to_back();
    out_t exp_seq[11];
    logic [6:0] ops[11];
    logic [10:0] rdy = 11'b011_1010_0101;
    exp_seq = '{e_fetch(1'b1), e_decode(1'b1), e_execute(), e_alu_wb(),
                e_fetch(1'b1), e_decode(1'b1), e_mem_addr(), e_mem_write(1'b1),
                e_fetch(1'b1), e_decode(1'b1), e_branch()};
    ops = '{OPC_R, OPC_R, OPC_R, OPC_R, OPC_SW, OPC_SW, OPC_SW, OPC_SW,
            OPC_BEQ, OPC_BEQ, OPC_BEQ};
    for (int i = 0; i < 11; i++) begin
      drive(ops[i], rdy[i] | (i == 0) | (i == 4) | (i == 7) | (i == 8), 1'b1, exp_seq[i]);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
    bus.opcode    = OPC_BAD;
    bus.mem_ready = 1'b1;
    test_reset();
    test_rtype();
    test_load_stall();
    test_store_stall();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Main control state machine for the multicycle RV32 core. It sequences the shared datapath (PC, IR, register file, single ALU, unified memory) through fetch/decode/execute/memory/writeback steps for R-type, `lw`, `sw` and `beq`. It drives the `ALUOp` input of the ALU control decoder and all datapath mux/enable strobes. Memory access steps stall on a ready handshake.

## Interface
- No parameters; all encodings come from the shared package.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low (0 = reset).
- `opcode` input 7: IR[6:0].
- `mem_ready` input 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite` output 1 each: datapath strobes.
- `ALUSrcA` output 2: 00 PC, 01 rs1 reg A, 10 OldPC.
- `ALUSrcB` output 2: 00 reg B, 01 const 4, 10 immediate.
- `ALUOp` output 2: 00 add, 01 sub (branch compare), 10 funct decode.
- `PCSource` output 1: 0 ALU result, 1 ALUOut.
- `illegal_op` output 1: unsupported opcode seen in DECODE.
- `instr_done` output 1: last cycle of an instruction.
- `state` output 4: current state, for debug.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH.
- Outputs not listed for a state are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite=1 and PCWrite=1 only when `mem_ready`=1.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when `mem_ready`=1.
- DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00, so ALUOut = OldPC+imm.
  - opcode 0110011 → EXECUTE.
  - 0000011 or 0100011 → MEM_ADDR.
  - 1100011 → BRANCH.
  - Any other opcode → FETCH, with illegal_op=1 and instr_done=1.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next state is MEM_READ for `lw`, MEM_WRITE for `sw`. Opcode is re-examined here; IR is stable.
- MEM_READ: MemRead=1, IorD=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, instr_done=1 → FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until `mem_ready`; instr_done=1 in the ready cycle → FETCH.
- EXECUTE: ALUSrcA=01, ALUSrcB=00, ALUOp=10 → ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, instr_done=1 → FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, instr_done=1 → FETCH. The datapath gates the PC write with ALU zero.

## Timing
- State is registered. Outputs decode combinationally from state; IRWrite, PCWrite and the MEM_WRITE instr_done are additionally gated by `mem_ready`.
- While `reset`=0, all outputs are forced to 0 combinationally, including `state`=FETCH encoding 0. The state register loads FETCH on the next edge.
- First FETCH occurs in the first cycle after `reset` returns to 1.
- Reset asserted mid-instruction aborts it: no further strobes, restart at FETCH. Any in-flight memory request is dropped.
- Cycle counts with `mem_ready` held at 1: R-type 4, `lw` 5, `sw` 4, `beq` 3, illegal 2. Each `mem_ready`=0 cycle adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- MemRead/MemWrite/IorD stay stable for the full duration of a stalled access.
- `mem_ready` is ignored in all non-memory states.
- Next-state function is total: an unreachable encoding goes to FETCH.

## Structure
- Package `multicycle_pkg` holds:
  - state enum (4-bit, FETCH=0);
  - opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH;
  - ALUOp codes;
  - ALUSrcA/ALUSrcB/PCSource select codes.
- The ALU control decoder later imports the same ALUOp constants.
- Single module: state register plus next-state logic plus output decode. No sub-module needed.

## Test plan
- Reset: `reset`=0 for 3 cycles with `mem_ready`=1 → all outputs 0. After release, cycle 1 shows state=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- R-type: opcode=0110011, `mem_ready`=1 → states FETCH, DECODE, EXECUTE, ALU_WB. ALUOp=10 in EXECUTE, RegWrite=1 and instr_done=1 only in ALU_WB. Back in FETCH on cycle 5.
- `lw` with stall: opcode=0000011, `mem_ready` low for 2 cycles in MEM_READ → 7-cycle instruction. MemRead=1 and IorD=1 held for 3 cycles; MEM_WB has RegWrite=1, MemtoReg=1.
- `sw`: opcode=0100011 → MemWrite=1 for exactly one cycle with `mem_ready`=1, RegWrite never 1, instr_done on that same cycle.
- `beq`: opcode=1100011 → BRANCH cycle 3 shows ALUOp=01, PCWriteCond=1, PCSource=1, PCWrite=0.
- Illegal opcode 1111111 → DECODE shows illegal_op=1, instr_done=1, then FETCH. Separately, `reset`=0 during MEM_READ → outputs 0 that cycle, FETCH next.
